// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: framed serial byte receiver (Clk/reset, in_data/data_ack in; data_out/data_valid/frame_err/overrun/busy out)
module shift_frame_ctrl #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       in_data,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic par;
  logic good;
  assign good = in_data && !(PARITY_EN && par);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE   ? (in_data ? IDLE : DATA) :
              state == DATA   ? (cnt == 3'd7 ? (PARITY_EN ? PARITY : STOP) : DATA) :
              state == PARITY ? STOP : IDLE;
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt        <= 3'd0;
      sh         <= 8'h00;
      par        <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == IDLE) begin
        cnt <= 3'd0;
        par <= 1'b0;
      end
      if (state == DATA) begin
        sh  <= {sh[6:0], in_data};
        par <= par ^ in_data;
        cnt <= cnt + 3'd1;
      end
      if (state == PARITY) par <= par ^ in_data;
      if (state == STOP && good) begin
        data_out   <= sh;
        data_valid <= 1'b1;
        overrun    <= data_valid && !data_ack;
        frame_err  <= 1'b0;
      end else begin
        if (data_ack) data_valid <= 1'b0;
        frame_err <= state == STOP;
      end
    end
  end
endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb_shift_frame_ctrl: randomized self-checking bench for shift_frame_ctrl with and without parity
module tb_shift_frame_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in1 = 1'b1, ack1 = 1'b0, in0 = 1'b1, ack0 = 1'b0;
  logic [7:0] out1, out0;
  logic val1, val0, fe1, fe0, ov1, ov0, busy1, busy0;
  int total = 0;
  int passed = 0;
  logic [7:0] m_out [2];
  logic m_valid [2];
  always #5 clk = ~clk;
  shift_frame_ctrl #(.PARITY_EN(1'b1)) u1 (
    .Clk(clk), .reset(reset), .in_data(in1), .data_ack(ack1),
    .data_out(out1), .data_valid(val1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
  );
  shift_frame_ctrl #(.PARITY_EN(1'b0)) u0 (
    .Clk(clk), .reset(reset), .in_data(in0), .data_ack(ack0),
    .data_out(out0), .data_valid(val0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int pe, input logic d, input logic a);
    if (pe == 1) begin
      in1 = d;
      ack1 = a;
    end else begin
      in0 = d;
      ack0 = a;
    end
  endtask
  function automatic logic [7:0] g_out(input int pe);
    return pe == 1 ? out1 : out0;
  endfunction
  function automatic logic g_val(input int pe);
    return pe == 1 ? val1 : val0;
  endfunction
  function automatic logic g_fe(input int pe);
    return pe == 1 ? fe1 : fe0;
  endfunction
  function automatic logic g_ov(input int pe);
    return pe == 1 ? ov1 : ov0;
  endfunction
  function automatic logic g_busy(input int pe);
    return pe == 1 ? busy1 : busy0;
  endfunction
  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 8'h00;
      m_valid[k] = 1'b0;
    end
  endtask
  task automatic send(input int pe, input logic [7:0] b, input logic p, input logic s, input logic a);
    logic good, exp_ov;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    good = s && (pe == 0 || ((ones + p) % 2 == 0));
    exp_ov = good && m_valid[pe] && !a;
    drive(pe, 1'b0, 1'b0);
    tick;
    total++;
    if (g_busy(pe) !== 1'b1 || g_fe(pe) !== 1'b0 || g_ov(pe) !== 1'b0)
      $display("FAIL start pe=%0d busy/fe/ov got %b%b%b want 100", pe, g_busy(pe), g_fe(pe), g_ov(pe));
    else passed++;
    for (int i = 7; i >= 0; i--) begin
      drive(pe, b[i], 1'b0);
      tick;
    end
    if (pe == 1) begin
      drive(pe, p, 1'b0);
      tick;
    end
    total++;
    if (g_val(pe) !== m_valid[pe] || g_busy(pe) !== 1'b1)
      $display("FAIL pre_stop pe=%0d valid/busy got %b%b want %b1", pe, g_val(pe), g_busy(pe), m_valid[pe]);
    else passed++;
    drive(pe, s, a);
    tick;
    if (good) begin
      m_out[pe] = b;
      m_valid[pe] = 1'b1;
    end else if (a) m_valid[pe] = 1'b0;
    total++;
    if (g_out(pe) !== m_out[pe] || g_val(pe) !== m_valid[pe] || g_fe(pe) !== !good ||
        g_ov(pe) !== exp_ov || g_busy(pe) !== 1'b0)
      $display("FAIL frame pe=%0d byte=%h out/valid/fe/ov/busy got %h %b%b%b%b want %h %b%b%b0",
               pe, b, g_out(pe), g_val(pe), g_fe(pe), g_ov(pe), g_busy(pe),
               m_out[pe], m_valid[pe], !good, exp_ov);
    else passed++;
    drive(pe, 1'b1, 1'b0);
  endtask
  task automatic idle(input int pe, input logic a);
    drive(pe, 1'b1, a);
    tick;
    if (a) m_valid[pe] = 1'b0;
    drive(pe, 1'b1, 1'b0);
    total++;
    if (g_val(pe) !== m_valid[pe] || g_fe(pe) !== 1'b0 || g_ov(pe) !== 1'b0 || g_busy(pe) !== 1'b0)
      $display("FAIL idle pe=%0d valid/fe/ov/busy got %b%b%b%b want %b000",
               pe, g_val(pe), g_fe(pe), g_ov(pe), g_busy(pe), m_valid[pe]);
    else passed++;
  endtask
  task automatic test_reset;
    model_reset();
    tick;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      total++;
      if (busy1 !== 1'b0 || val1 !== 1'b0 || out1 !== 8'h00 || busy0 !== 1'b0 || val0 !== 1'b0 || out0 !== 8'h00)
        $display("FAIL reset_idle cycle %0d busy/valid/out got %b%b%h %b%b%h want 00 00", i, busy1, val1, out1, busy0, val0, out0);
      else passed++;
    end
  endtask
  task automatic test_good_frame;
    send(1, 8'hB4, 1'b0, 1'b1, 1'b0);
    total++;
    if (out1 !== 8'hB4 || val1 !== 1'b1)
      $display("FAIL good_b4 out/valid got %h %b want b4 1", out1, val1);
    else passed++;
    idle(1, 1'b1);
    idle(1, 1'b0);
  endtask
  task automatic test_errors;
    send(1, 8'hB4, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);
    send(1, 8'h3C, 1'b0, 1'b0, 1'b0);
    total++;
    if (out1 !== 8'hB4 || val1 !== 1'b0)
      $display("FAIL stop_err out/valid got %h %b want b4 0", out1, val1);
    else passed++;
    idle(1, 1'b0);
  endtask
  task automatic test_back_to_back;
    send(1, 8'hB4, 1'b0, 1'b1, 1'b0);
    send(1, 8'h5A, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    send(1, 8'hB4, 1'b0, 1'b1, 1'b0);
    send(1, 8'h5A, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
  endtask
  task automatic test_reset_mid;
    drive(1, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b0);
      tick;
    end
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (busy1 !== 1'b0 || val1 !== 1'b0 || out1 !== 8'h00)
      $display("FAIL reset_mid busy/valid/out got %b%b%h want 0000", busy1, val1, out1);
    else passed++;
    tick;
    reset = 1'b0;
    send(1, 8'h81, 1'b0, 1'b1, 1'b0);
    total++;
    if (out1 !== 8'h81)
      $display("FAIL after_abort out got %h want 81", out1);
    else passed++;
  endtask
  task automatic test_no_parity;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    total++;
    if (out0 !== 8'hA5 || val0 !== 1'b1)
      $display("FAIL nopar_a5 out/valid got %h %b want a5 1", out0, val0);
    else passed++;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(0, 1'b1);
  endtask
  task automatic test_random;
    for (int n = 0; n < 120; n++) begin
      int pe;
      logic [7:0] b;
      logic p;
      pe = int'($urandom_range(0, 1));
      b = 8'($urandom);
      p = (^b) ^ ($urandom_range(0, 5) == 0);
      send(pe, b, p, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle(pe, $urandom_range(0, 3) == 0);
    end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_no_parity();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
